// File: rtl/mac_rx_frame_fifo.sv
// mac_rx_frame_fifo
// Store-and-forward frame buffer between the RX side of one mac_rgmii port
// and the TX side of the other. Incoming frames are written speculatively
// into a circular RAM; only frames that end good and error-free are
// committed, all others are discarded by rewinding the write pointer.
// Committed frames are replayed gap-free, each followed by IFG idle cycles,
// because the downstream TX path cannot apply backpressure.
//
// Ports
//   aclk, areset_n        : clock, asynchronous active-low reset
//   mac_rx_data_i/valid_i : RX byte stream
//   mac_rx_sof_i/eof_i    : frame delimiters, qualified by valid
//   mac_rx_fr_good_i      : frame good, looked at on the eof beat only
//   mac_rx_fr_err_i       : frame error, looked at any cycle a frame is open
//   mac_tx_data/valid     : TX byte stream
//   mac_tx_sof/eof        : TX frame delimiters
//   frm_ok_cnt            : committed frame count (wraps)
//   frm_drop_cnt          : discarded frame count (wraps)
//   ovf_o                 : one-cycle pulse when a frame is dropped for lack of space
module mac_rx_frame_fifo #(
  parameter int ADDR_W = 12,
  parameter int IFG    = 12,
  parameter int CNT_W  = 16
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic [7:0]       mac_rx_data_i,
  input  logic             mac_rx_valid_i,
  input  logic             mac_rx_sof_i,
  input  logic             mac_rx_eof_i,
  input  logic             mac_rx_fr_good_i,
  input  logic             mac_rx_fr_err_i,
  output logic [7:0]       mac_tx_data,
  output logic             mac_tx_valid,
  output logic             mac_tx_sof,
  output logic             mac_tx_eof,
  output logic [CNT_W-1:0] frm_ok_cnt,
  output logic [CNT_W-1:0] frm_drop_cnt,
  output logic             ovf_o
);

  localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_GAP} rd_state_e;

  // Each entry is {eof_marker, data}.
  logic [8:0] mem [2**ADDR_W];

  ptr_t       wr_ptr, wr_commit, rd_ptr;
  logic       in_frame, drop, drop_ovf;

  // Write-side next-state signals
  ptr_t       wr_ptr_nx, wr_commit_nx, wr_addr, base, ptr_after;
  logic [8:0] wr_data;
  logic       wr_en, in_frame_nx, drop_nx, drop_ovf_nx;
  logic       active, cur_drop, cur_ovf, full_b, ovf_hit, frame_bad;
  logic       ok_inc, ovf_nx;
  logic [1:0] drop_inc;

  // Read-side signals
  rd_state_e        state, state_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic [8:0]       rd_q;
  logic             rd_en, load_out, first_out;

  // ---------------------------------------------------------------- write side
  // NOTE: every signal assigned in this combinational block gets a default
  // first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    wr_en        = 1'b0;
    wr_addr      = wr_ptr;
    wr_data      = '0;
    wr_ptr_nx    = wr_ptr;
    wr_commit_nx = wr_commit;
    in_frame_nx  = in_frame;
    drop_nx      = drop;
    drop_ovf_nx  = drop_ovf;
    ok_inc       = 1'b0;
    drop_inc     = 2'd0;
    ovf_nx       = 1'b0;
    active       = 1'b0;
    base         = wr_ptr;
    cur_drop     = drop;
    cur_ovf      = drop_ovf;
    full_b       = 1'b0;
    ovf_hit      = 1'b0;
    frame_bad    = 1'b0;
    ptr_after    = wr_ptr;

    if (mac_rx_valid_i && mac_rx_sof_i) begin
      // A new frame always restarts at the last commit point; an open frame
      // is abandoned and counted as dropped on the same beat.
      active   = 1'b1;
      base     = wr_commit;
      cur_drop = 1'b0;
      cur_ovf  = 1'b0;
      if (in_frame) drop_inc = 2'd1;
    end else if (mac_rx_valid_i && in_frame) begin
      active = 1'b1;
    end else if (in_frame && mac_rx_fr_err_i) begin
      drop_nx = 1'b1;
    end

    if (active) begin
      full_b    = (base + ptr_t'(1)) == rd_ptr;
      ovf_hit   = !cur_drop && full_b;
      frame_bad = cur_drop || full_b || mac_rx_fr_err_i;
      ptr_after = base;
      if (!cur_drop && !full_b) begin
        wr_en     = 1'b1;
        wr_addr   = base;
        wr_data   = {mac_rx_eof_i, mac_rx_data_i};
        ptr_after = base + ptr_t'(1);
      end
      if (mac_rx_eof_i) begin
        in_frame_nx = 1'b0;
        drop_nx     = 1'b0;
        drop_ovf_nx = 1'b0;
        if (mac_rx_fr_good_i && !frame_bad) begin
          wr_commit_nx = ptr_after;
          wr_ptr_nx    = ptr_after;
          ok_inc       = 1'b1;
        end else begin
          wr_ptr_nx = wr_commit;
          drop_inc  = drop_inc + 2'd1;
          ovf_nx    = cur_ovf || ovf_hit;
        end
      end else begin
        in_frame_nx = 1'b1;
        drop_nx     = frame_bad;
        drop_ovf_nx = cur_ovf || ovf_hit;
        wr_ptr_nx   = ptr_after;
      end
    end
  end

  // NOTE: the frame store has no reset; its contents are only ever read
  // below wr_commit, which reset returns to rd_ptr, so stale data is unreachable.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr       <= '0;
      wr_commit    <= '0;
      in_frame     <= 1'b0;
      drop         <= 1'b0;
      drop_ovf     <= 1'b0;
      frm_ok_cnt   <= '0;
      frm_drop_cnt <= '0;
      ovf_o        <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nx;
      wr_commit    <= wr_commit_nx;
      in_frame     <= in_frame_nx;
      drop         <= drop_nx;
      drop_ovf     <= drop_ovf_nx;
      frm_ok_cnt   <= frm_ok_cnt + CNT_W'(ok_inc);
      frm_drop_cnt <= frm_drop_cnt + CNT_W'(drop_inc);
      ovf_o        <= ovf_nx;
    end
  end

  // ----------------------------------------------------------------- read side
  // rd_q holds the entry fetched on the previous cycle. A new fetch is issued
  // only when the entry just moved to the output is not an eof, so rd_ptr
  // always stops one past the eof entry.
  always_comb begin
    state_nx  = state;
    gap_nx    = gap_cnt;
    rd_en     = 1'b0;
    load_out  = 1'b0;
    first_out = 1'b0;
    unique case (state)
      S_IDLE: begin
        gap_nx = '0;
        if (rd_ptr != wr_commit) begin
          rd_en    = 1'b1;
          state_nx = S_PRIME;
        end
      end
      S_PRIME: begin
        load_out  = 1'b1;
        first_out = 1'b1;
        rd_en     = !rd_q[8];
        state_nx  = S_STREAM;
      end
      S_STREAM: begin
        gap_nx = '0;
        if (mac_tx_eof) begin
          state_nx = S_GAP;
        end else begin
          load_out = 1'b1;
          rd_en    = !rd_q[8];
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(IFG - 1)) state_nx = S_IDLE;
        else                            gap_nx   = gap_cnt + GAP_W'(1);
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state        <= S_IDLE;
      gap_cnt      <= '0;
      rd_ptr       <= '0;
      rd_q         <= '0;
      mac_tx_data  <= '0;
      mac_tx_valid <= 1'b0;
      mac_tx_sof   <= 1'b0;
      mac_tx_eof   <= 1'b0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_nx;
      if (rd_en) begin
        rd_q   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      if (load_out) begin
        mac_tx_data  <= rd_q[7:0];
        mac_tx_valid <= 1'b1;
        mac_tx_sof   <= first_out;
        mac_tx_eof   <= rd_q[8];
      end else begin
        mac_tx_data  <= '0;
        mac_tx_valid <= 1'b0;
        mac_tx_sof   <= 1'b0;
        mac_tx_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mac_rx_frame_fifo.md
# mac_rx_frame_fifo

Store-and-forward frame buffer between the RX logic side of one `mac_rgmii` port and the TX logic side of the other port in the RGMII bridge. It accepts the byte stream with sof/eof/valid plus frame-quality flags and writes each frame into a circular RAM. Only frames that complete with `fr_good=1` and no `fr_err` are committed; all others are discarded by rewinding the write pointer. Committed frames are replayed gap-free on the TX interface, followed by a fixed inter-frame idle, because `mac_rgmii` TX has no backpressure.

## Interface
- `ADDR_W`, 12: RAM address width. Depth is 2^ADDR_W entries of 9 bits (data + eof marker). Usable capacity is 2^ADDR_W−1.
- `IFG`, 12: number of idle cycles (valid=0) after each TX eof. Must be ≥1.
- `CNT_W`, 16: width of the statistics counters.

- `aclk` in 1: single clock (mac_gtx_clk, 125 MHz).
- `areset_n` in 1: asynchronous active-low reset.
- `mac_rx_data_i` in 8: RX byte.
- `mac_rx_valid_i` in 1: byte valid.
- `mac_rx_sof_i` in 1: first byte of frame; qualified by valid.
- `mac_rx_eof_i` in 1: last byte of frame; qualified by valid.
- `mac_rx_fr_good_i` in 1: frame good; sampled on the eof beat only.
- `mac_rx_fr_err_i` in 1: frame error; sampled any cycle while a frame is open, including the eof beat.
- `mac_tx_data` out 8: TX byte.
- `mac_tx_valid` out 1: TX byte valid.
- `mac_tx_sof` out 1: first TX byte.
- `mac_tx_eof` out 1: last TX byte.
- `frm_ok_cnt` out CNT_W: count of committed frames; wraps.
- `frm_drop_cnt` out CNT_W: count of discarded frames; wraps.
- `ovf_o` out 1: one-cycle pulse when a frame is dropped because of overflow.

## Operation
- Write side:
  - Registers `wr_ptr` (speculative write pointer), `wr_commit`, and `in_frame`, `drop` flags.
  - sof & valid: set `in_frame`, clear `drop`, write the byte at `wr_commit` (a restart always begins at `wr_commit`).
  - valid, no sof, `in_frame`=0: beat ignored.
  - Full is `wr_ptr+1 == rd_ptr` (modulo 2^ADDR_W). A write attempted while full sets `drop`, and no further writes occur for that frame.
  - fr_err while `in_frame` sets `drop`.
  - eof & valid: the eof byte is written with marker=1 unless `drop` is set or the RAM is full.
    - Commit if `fr_good=1` and `drop`=0 and fr_err=0 on that beat: `wr_commit <= wr_ptr_next`, `frm_ok_cnt++`.
    - Otherwise: `wr_ptr <= wr_commit`, `frm_drop_cnt++`, and `ovf_o`=1 if the cause was full.
    - In both cases clear `in_frame`.
  - sof while `in_frame`: abort the open frame (`frm_drop_cnt++`, rewind), then start the new frame on the same beat.
  - sof & eof on the same beat: a 1-byte frame, handled by the same commit rules.
- Read side FSM:
  - IDLE: if `rd_ptr != wr_commit`, issue a RAM read at `rd_ptr`, advance `rd_ptr`, go to PRIME.
  - PRIME: issue the next read and advance `rd_ptr`, unless the first entry carried the eof marker. Go to STREAM.
  - STREAM: valid=1 every cycle.
    - sof=1 on the first byte.
    - Keep reading sequentially.
    - On the output byte whose marker=1, assert eof, stop reading, go to GAP.
    - Over-read past eof is not permitted: `rd_ptr` always ends one past the eof entry.
  - GAP: count IFG idle cycles with valid=0, then go to IDLE.
- `rd_ptr` frees space only as bytes are read. Simultaneous write commit and read is legal; the read side uses only `wr_commit`.

## Timing
- Reset values:
  - All outputs are 0.
  - `wr_ptr`, `wr_commit`, `rd_ptr` are 0.
  - FSM is in IDLE; `in_frame` and `drop` are 0.
- Reset mid-operation: all buffered and partial frames are lost. After release, beats are ignored until the next sof.
- Latency: input eof beat at cycle T. `wr_commit` updates at T+1. IDLE issues the read at T+1. PRIME at T+2. `mac_tx_sof`/`valid` at T+3.
- A frame of N bytes occupies exactly N consecutive TX cycles.
- Next TX sof comes no earlier than IFG+2 cycles after the previous TX eof (GAP, then IDLE, then PRIME).
- `ovf_o` and counter updates take effect on the cycle after the eof beat.
- Pointer arithmetic is ADDR_W bits and wraps naturally. Frames may straddle the RAM end.

## Test plan
- 64-byte good frame (0x00..0x3F), fr_good=1 → TX bytes identical; sof on 0x00, eof on 0x3F; sof at T+3; `frm_ok_cnt`=1.
- 64-byte frame with fr_good=0 at eof → no TX activity; `frm_drop_cnt`=1. A following 10-byte good frame is output correctly.
- fr_err pulse on byte 20 of a 60-byte frame with fr_good=1 → frame dropped; `frm_drop_cnt`=1; nothing transmitted.
- ADDR_W=6, 100-byte frame with TX blocked by a pending prior frame → `ovf_o` pulses once. The 100-byte frame is not sent. A subsequent 20-byte frame is sent intact.
- Three back-to-back 64-byte good frames, input IFG 0 → three TX frames with exactly IFG+2=14 idle cycles between an eof and the next sof. Wrap-around is exercised with ADDR_W=7.
- 1-byte frame (sof=eof=1, 0xA5) → a single TX beat with sof=eof=valid=1, data 0xA5. `areset_n` pulsed mid-stream of a 64-byte frame → outputs 0 immediately, counters 0, no residual TX afterwards.
